// File: rtl/vx_mem_perf_mon_pkg.sv
// Shared constants and types for the memory performance monitor.
// The packed bundle lets core-level perf interfaces carry one monitor's outputs.
package vx_mem_perf_mon_pkg;

    localparam int PERF_CTR_BITS  = 44;
    localparam int PERF_PEND_BITS = 16;

    typedef struct packed {
        logic [PERF_CTR_BITS-1:0]  reads;
        logic [PERF_CTR_BITS-1:0]  writes;
        logic [PERF_CTR_BITS-1:0]  rsps;
        logic [PERF_CTR_BITS-1:0]  latency_sum;
        logic [PERF_PEND_BITS-1:0] pending_reads;
        logic [PERF_PEND_BITS-1:0] peak_pending;
        logic                      underflow;
    } mem_perf_mon_t;

endpackage

// File: rtl/vx_mem_perf_mon_if.sv
// Per-channel memory request/response handshake bundle observed by the monitor.
// The monitor only listens, so it takes the slave modport (all inputs).
interface vx_mem_perf_mon_if #(
    parameter int NUM_REQS = 4
);
    logic [NUM_REQS-1:0] req_valid;
    logic [NUM_REQS-1:0] req_ready;
    logic [NUM_REQS-1:0] req_rw;
    logic [NUM_REQS-1:0] rsp_valid;
    logic [NUM_REQS-1:0] rsp_ready;

    modport master (
        output req_valid, req_ready, req_rw, rsp_valid, rsp_ready
    );

    modport slave (
        input req_valid, req_ready, req_rw, rsp_valid, rsp_ready
    );
endinterface

// File: rtl/vx_mem_perf_mon_popcount.sv
// Combinational population count of an N-bit vector.
module vx_mem_perf_mon_popcount #(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] in_i,
    output logic [W-1:0] cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + W'(in_i[i]);
        end
    end
endmodule

// File: rtl/vx_mem_perf_mon.sv
// Memory performance monitor: counts read/write/response handshakes, tracks
// outstanding reads and accumulates their per-cycle sum as a latency measure.
module vx_mem_perf_mon
    import vx_mem_perf_mon_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int CTR_WIDTH  = PERF_CTR_BITS,
    parameter int PEND_WIDTH = PERF_PEND_BITS,
    parameter int REQ_DELAY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_mem_perf_mon_if.slave      bus_if,
    input  logic                  clear_i,
    input  logic                  freeze_i,
    output logic [CTR_WIDTH-1:0]  reads_o,
    output logic [CTR_WIDTH-1:0]  writes_o,
    output logic [CTR_WIDTH-1:0]  rsps_o,
    output logic [CTR_WIDTH-1:0]  latency_sum_o,
    output logic [PEND_WIDTH-1:0] pending_reads_o,
    output logic [PEND_WIDTH-1:0] peak_pending_o,
    output logic                  underflow_o
);
    localparam int CW = $clog2(NUM_REQS + 1);
    localparam int PW = PEND_WIDTH + 1;

    logic [NUM_REQS-1:0] rd_fire, wr_fire, rsp_fire;
    logic [NUM_REQS-1:0] rd_vec, wr_vec;
    logic [CW-1:0]       rd_cnt, wr_cnt, rsp_cnt;

    assign rd_fire  = bus_if.req_valid & bus_if.req_ready & ~bus_if.req_rw;
    assign wr_fire  = bus_if.req_valid & bus_if.req_ready &  bus_if.req_rw;
    assign rsp_fire = bus_if.rsp_valid & bus_if.rsp_ready;

    // Optional alignment stage so request counts line up with downstream timing.
    if (REQ_DELAY == 1) begin : g_dly
        logic [NUM_REQS-1:0] rd_dly_q, wr_dly_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_dly_q <= '0;
                wr_dly_q <= '0;
            end else begin
                rd_dly_q <= rd_fire;
                wr_dly_q <= wr_fire;
            end
        end
        assign rd_vec = rd_dly_q;
        assign wr_vec = wr_dly_q;
    end else begin : g_nodly
        assign rd_vec = rd_fire;
        assign wr_vec = wr_fire;
    end

    vx_mem_perf_mon_popcount #(.N(NUM_REQS), .W(CW)) u_pc_rd  (.in_i(rd_vec),   .cnt_o(rd_cnt));
    vx_mem_perf_mon_popcount #(.N(NUM_REQS), .W(CW)) u_pc_wr  (.in_i(wr_vec),   .cnt_o(wr_cnt));
    vx_mem_perf_mon_popcount #(.N(NUM_REQS), .W(CW)) u_pc_rsp (.in_i(rsp_fire), .cnt_o(rsp_cnt));

    logic [CTR_WIDTH-1:0]  reads_q, reads_d, writes_q, writes_d;
    logic [CTR_WIDTH-1:0]  rsps_q, rsps_d, lat_q, lat_d;
    logic [PEND_WIDTH-1:0] pend_q, pend_d, peak_q, peak_d;
    logic                  underflow_q, underflow_d;
    logic [PW-1:0]         pend_sum, pend_diff;
    logic                  uf_ev;

    function automatic logic [CTR_WIDTH-1:0] sat_add(input logic [CTR_WIDTH-1:0] a,
                                                     input logic [CTR_WIDTH-1:0] b);
        logic [CTR_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CTR_WIDTH] ? {CTR_WIDTH{1'b1}} : s[CTR_WIDTH-1:0];
    endfunction

    // One extra bit absorbs the carry so saturation and underflow are both visible.
    assign pend_sum  = {1'b0, pend_q} + PW'(rd_cnt);
    assign uf_ev     = PW'(rsp_cnt) > pend_sum;
    assign pend_diff = pend_sum - PW'(rsp_cnt);

    always_comb begin
        if (uf_ev) begin
            pend_d = '0;
        end else if (pend_diff[PEND_WIDTH]) begin
            pend_d = '1;
        end else begin
            pend_d = pend_diff[PEND_WIDTH-1:0];
        end
    end

    always_comb begin
        reads_d     = reads_q;
        writes_d    = writes_q;
        rsps_d      = rsps_q;
        lat_d       = lat_q;
        peak_d      = peak_q;
        underflow_d = underflow_q | uf_ev;
        if (clear_i) begin
            reads_d     = '0;
            writes_d    = '0;
            rsps_d      = '0;
            lat_d       = '0;
            underflow_d = 1'b0;
            peak_d      = pend_d;
        end else if (!freeze_i) begin
            reads_d  = sat_add(reads_q,  CTR_WIDTH'(rd_cnt));
            writes_d = sat_add(writes_q, CTR_WIDTH'(wr_cnt));
            rsps_d   = sat_add(rsps_q,   CTR_WIDTH'(rsp_cnt));
            lat_d    = sat_add(lat_q,    CTR_WIDTH'(pend_q));
            peak_d   = (pend_d > peak_q) ? pend_d : peak_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reads_q     <= '0;
            writes_q    <= '0;
            rsps_q      <= '0;
            lat_q       <= '0;
            pend_q      <= '0;
            peak_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            reads_q     <= reads_d;
            writes_q    <= writes_d;
            rsps_q      <= rsps_d;
            lat_q       <= lat_d;
            pend_q      <= pend_d;
            peak_q      <= peak_d;
            underflow_q <= underflow_d;
        end
    end

    assign reads_o         = reads_q;
    assign writes_o        = writes_q;
    assign rsps_o          = rsps_q;
    assign latency_sum_o   = lat_q;
    assign pending_reads_o = pend_q;
    assign peak_pending_o  = peak_q;
    assign underflow_o     = underflow_q;

endmodule

// File: doc/vx_mem_perf_mon.md
VX_MEM_PERF_MON -- requirements
Module: VX_mem_perf_mon

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of monitored memory request/response channels (1..16).
REQ-002 SHALL have parameter CTR_WIDTH, default 44, width of the event and latency counters.
REQ-003 SHALL have parameter PEND_WIDTH, default 16, width of the outstanding-read counter and the peak register.
REQ-004 SHALL have parameter REQ_DELAY, default 1, request-fire alignment stages (0 or 1).
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports req_valid, req_ready, req_rw  in  NUM_REQS each  per-channel request handshake; rw=1 is a write.
REQ-008 SHALL have ports rsp_valid, rsp_ready  in  NUM_REQS each  per-channel read-response handshake.
REQ-009 SHALL have port clear  in  1  synchronous accumulator clear.
REQ-010 SHALL have port freeze  in  1  hold the accumulators.
REQ-011 SHALL have ports reads, writes, rsps, latency_sum  out  CTR_WIDTH each  registered accumulators.
REQ-012 SHALL have ports pending_reads, peak_pending  out  PEND_WIDTH each  current and maximum outstanding reads.
REQ-013 SHALL have port underflow  out  1  sticky: a response arrived with no outstanding read.

Function
REQ-014 SHALL define per-channel rd_fire = valid&ready&~rw, wr_fire = valid&ready&rw, rsp_fire = rsp_valid&rsp_ready.
REQ-015 SHALL, for REQ_DELAY=1, register the rd_fire/wr_fire vectors one stage before counting; for REQ_DELAY=0, count them directly.
REQ-016 SHALL reduce each vector per cycle to a population count of width CLOG2(NUM_REQS+1).
REQ-017 SHALL make a request handshake in cycle t visible in reads/writes at t+1+REQ_DELAY, and a response in cycle t visible in rsps and pending_reads at t+1.
REQ-018 SHALL update pending_reads <= pending_reads + rd_cnt - rsp_cnt, with rd_cnt and rsp_cnt both taken from the same update cycle.
REQ-019 SHALL, when rsp_cnt > pending_reads + rd_cnt, clamp pending_reads to 0 and set underflow.
REQ-020 SHALL saturate pending_reads at all-ones, never wrapping.
REQ-021 SHALL add the pre-update pending_reads value into latency_sum every non-frozen cycle.
REQ-022 SHALL saturate reads, writes, rsps and latency_sum at all-ones; they hold there until clear or reset.
REQ-023 SHALL update peak_pending <= max(peak_pending, next pending_reads) every non-frozen cycle.
REQ-024 SHALL, while freeze=1, hold reads, writes, rsps, latency_sum and peak_pending, while pending_reads, underflow and the delay stage keep tracking.
REQ-025 SHALL, on clear=1, next cycle zero reads, writes, rsps, latency_sum and underflow, and load peak_pending with next pending_reads; pending_reads itself SHALL NOT be cleared.
REQ-026 SHALL give clear priority over freeze when both are asserted.
REQ-027 SHALL count events present in the clear cycle into pending_reads only; they SHALL NOT appear in the accumulators.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-traffic, asynchronously drive every output and the delay stage to 0.
REQ-029 SHALL resume counting on the first rising edge after reset deasserts, dropping any handshakes in flight in the delay stage.

Structure
REQ-030 SHALL take the CTR_WIDTH default from the shared package perf counter width constant (PERF_CTR_BITS) in VX_gpu_pkg.
REQ-031 SHALL place a packed typedef of the output bundle (mem_perf_mon_t) in VX_gpu_pkg so that core-level perf interfaces can carry it.
REQ-032 SHALL instantiate the existing VX_popcount sub-module, once per fire vector; all other logic SHALL be inline.

Verification
REQ-033 SHALL cover REQ_DELAY=1, NUM_REQS=4: 3 reads fire at cycle 0, 3 responses at cycle 5 -> reads=3 at cycle 2; pending_reads=3 for cycles 2..5, 0 at cycle 6; latency_sum=12; peak_pending=3.
REQ-034 SHALL cover simultaneous events: 2 reads + 1 write + 1 response in one cycle with pending_reads=5 -> pending_reads=6, writes+1, rsps+1.
REQ-035 SHALL cover underflow: 1 response with pending_reads=0 -> pending_reads stays 0, underflow=1 until clear.
REQ-036 SHALL cover saturation: CTR_WIDTH=8, 300 reads -> reads holds 255.
REQ-037 SHALL cover clear and freeze: freeze for 10 cycles with traffic -> accumulators unchanged and pending_reads tracks; clear+freeze together -> accumulators 0 and peak_pending = pending_reads.
REQ-038 SHALL cover reset: async reset pulse between clock edges with pending_reads=7 -> all outputs 0 immediately, with no clock edge.
